// File: rtl/operand_loader_if.sv
// Bus bundle between the switch/button front panel and operand_loader.
// The master drives the raw panel inputs; the slave (the loader) drives the captured values and strobes.
interface operand_loader_if #(
  parameter int OP_W = 3
);
  logic [7:0]      sw;
  logic            btn_load;
  logic            btn_cancel;
  logic [7:0]      a_out;
  logic [7:0]      b_out;
  logic [OP_W-1:0] op_out;
  logic            ld_a;
  logic            ld_b;
  logic            ld_op;
  logic            start;

  modport master (
    output sw, btn_load, btn_cancel,
    input  a_out, b_out, op_out, ld_a, ld_b, ld_op, start
  );

  modport slave (
    input  sw, btn_load, btn_cancel,
    output a_out, b_out, op_out, ld_a, ld_b, ld_op, start
  );
endinterface

// File: rtl/operand_loader.sv
// Captures operand A, operand B and the opcode from slide switches on successive load presses, then pulses start.
// Build option OPERAND_LOADER_DEBOUNCE_EN: when defined the load button is debounced, otherwise the synchronised level is used directly.
module operand_loader #(
  parameter int DBNC_CYCLES = 250000,
  parameter int OP_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  operand_loader_if.slave  bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    START   = 2'd3
  } state_e;

  // Out-of-range settings elaborate a named marker block visible in the hierarchy.
  if (DBNC_CYCLES < 1 || DBNC_CYCLES > 24'hFFFFFF || OP_W < 1 || OP_W > 8) begin : g_param_out_of_range
  end

  logic [7:0] sw_s1_q, sw_s2_q;
  logic       btn_s1_q, btn_s2_q;
  logic       cnl_s1_q, cnl_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      cnl_s1_q <= 1'b0;
      cnl_s2_q <= 1'b0;
    end else begin
      sw_s1_q  <= bus.sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= bus.btn_load;
      btn_s2_q <= btn_s1_q;
      cnl_s1_q <= bus.btn_cancel;
      cnl_s2_q <= cnl_s1_q;
    end
  end

  logic db;

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam logic [23:0] CNT_LAST = 24'(DBNC_CYCLES - 1);

  logic [23:0] cnt_q;
  logic        db_q;

  // The level only moves after DBNC_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (btn_s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_q  <= btn_s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 24'd1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign db = db_q;
`else
  assign db = btn_s2_q;
`endif

  logic db_d_q;
  logic press;

  always_ff @(posedge clk) begin
    if (rst) db_d_q <= 1'b0;
    else     db_d_q <= db;
  end

  assign press = db & ~db_d_q;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cnl_s2_q) begin
      state_d = WAIT_A;
    end else begin
      case (state_q)
        WAIT_A:  if (press) state_d = WAIT_B;
        WAIT_B:  if (press) state_d = WAIT_OP;
        WAIT_OP: if (press) state_d = START;
        START:   state_d = WAIT_A;
        default: state_d = WAIT_A;
      endcase
    end
  end

  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            ld_a_q, ld_a_d, ld_b_q, ld_b_d, ld_op_q, ld_op_d, start_q, start_d;

  // Cancel wins over a coinciding press and over the start pulse.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ld_a_d  = 1'b0;
    ld_b_d  = 1'b0;
    ld_op_d = 1'b0;
    start_d = 1'b0;
    if (!cnl_s2_q) begin
      case (state_q)
        WAIT_A:  if (press) begin a_d  = sw_s2_q;           ld_a_d  = 1'b1; end
        WAIT_B:  if (press) begin b_d  = sw_s2_q;           ld_b_d  = 1'b1; end
        WAIT_OP: if (press) begin op_d = sw_s2_q[OP_W-1:0]; ld_op_d = 1'b1; end
        START:   start_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      ld_op_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ld_a_q  <= ld_a_d;
      ld_b_q  <= ld_b_d;
      ld_op_q <= ld_op_d;
      start_q <= start_d;
    end
  end

  assign bus.a_out  = a_q;
  assign bus.b_out  = b_q;
  assign bus.op_out = op_q;
  assign bus.ld_a   = ld_a_q;
  assign bus.ld_b   = ld_b_q;
  assign bus.ld_op  = ld_op_q;
  assign bus.start  = start_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader; expected latencies follow the OPERAND_LOADER_DEBOUNCE_EN build setting.
module tb_operand_loader;
  localparam int DBNC = 4;
  localparam int OP_W = 3;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + DBNC;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;
  int n_ld_a = 0, n_ld_b = 0, n_ld_op = 0, n_start = 0;

  operand_loader_if #(.OP_W(OP_W)) bus ();

  operand_loader #(.DBNC_CYCLES(DBNC), .OP_W(OP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and strobe monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    n_ld_a  += int'(bus.ld_a);
    n_ld_b  += int'(bus.ld_b);
    n_ld_op += int'(bus.ld_op);
    n_start += int'(bus.start);
    checks++;
    if (int'(bus.ld_a) + int'(bus.ld_b) + int'(bus.ld_op) + int'(bus.start) > 1) begin
      errors++;
      $display("FAIL strobe_onehot got=%b%b%b%b exp=at most one high", bus.ld_a, bus.ld_b, bus.ld_op, bus.start);
    end
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.btn_load = 1'b0;
    bus.btn_cancel = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic press_to_ld(input logic [7:0] v);
    bus.sw = v;
    cyc(1);
    bus.btn_load = 1'b1;
    cyc(LAT + 1);
  endtask

  task automatic release_btn();
    bus.btn_load = 1'b0;
    cyc(LAT + 2);
  endtask

  function automatic int strobes();
    return n_ld_a + n_ld_b + n_ld_op + n_start;
  endfunction

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    bus.sw = 8'h00;
    bus.btn_load = 1'b0;
    bus.btn_cancel = 1'b0;
    cyc(3);
    checks++; if (bus.a_out !== 8'h00) begin errors++; $display("FAIL reset_a_out got=%h exp=00", bus.a_out); end
    checks++; if (bus.b_out !== 8'h00) begin errors++; $display("FAIL reset_b_out got=%h exp=00", bus.b_out); end
    checks++; if (bus.op_out !== 3'd0) begin errors++; $display("FAIL reset_op_out got=%h exp=0", bus.op_out); end
    checks++; if ({bus.ld_a, bus.ld_b, bus.ld_op, bus.start} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.ld_a, bus.ld_b, bus.ld_op, bus.start}); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    rst = 1'b0;
    cyc(3);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_latency();
    int a0;
    bus.sw = 8'h3C;
    cyc(1);
    a0 = n_ld_a;
    bus.btn_load = 1'b1;
    cyc(LAT);
    checks++; if (bus.ld_a !== 1'b0) begin errors++; $display("FAIL lat_early_ld_a got=%b exp=0", bus.ld_a); end
    cyc(1);
    checks++; if (bus.ld_a !== 1'b1) begin errors++; $display("FAIL lat_ld_a got=%b exp=1", bus.ld_a); end
    checks++; if (bus.a_out !== 8'h3C) begin errors++; $display("FAIL lat_a_out got=%h exp=3c", bus.a_out); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL lat_state got=%0d exp=1", state_o); end
    cyc(1);
    checks++; if (bus.ld_a !== 1'b0) begin errors++; $display("FAIL lat_ld_a_width got=%b exp=0", bus.ld_a); end
    cyc(10);
    checks++; if (n_ld_a - a0 !== 1) begin errors++; $display("FAIL hold_one_event got=%0d exp=1", n_ld_a - a0); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL hold_state got=%0d exp=1", state_o); end
    release_btn();
  endtask

  task automatic test_full_seq();
    press_to_ld(8'hA5);
    checks++; if (bus.ld_b !== 1'b1) begin errors++; $display("FAIL seq_ld_b got=%b exp=1", bus.ld_b); end
    checks++; if (bus.b_out !== 8'hA5) begin errors++; $display("FAIL seq_b_out got=%h exp=a5", bus.b_out); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL seq_state_b got=%0d exp=2", state_o); end
    release_btn();
    press_to_ld(8'h05);
    checks++; if (bus.ld_op !== 1'b1) begin errors++; $display("FAIL seq_ld_op got=%b exp=1", bus.ld_op); end
    checks++; if (bus.op_out !== 3'b101) begin errors++; $display("FAIL seq_op_out got=%b exp=101", bus.op_out); end
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL seq_state_start got=%0d exp=3", state_o); end
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL seq_start_early got=%b exp=0", bus.start); end
    cyc(1);
    checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL seq_start got=%b exp=1", bus.start); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL seq_state_back got=%0d exp=0", state_o); end
    cyc(1);
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL seq_start_width got=%b exp=0", bus.start); end
    checks++; if ({bus.a_out, bus.b_out} !== 16'h3CA5) begin errors++; $display("FAIL seq_held got=%h exp=3ca5", {bus.a_out, bus.b_out}); end
    release_btn();
  endtask

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  task automatic test_bounce();
    int s0, a0;
    s0 = strobes();
    for (int i = 0; i < 4; i++) begin
      bus.btn_load = (i % 2 == 0);
      cyc(2);
    end
    bus.btn_load = 1'b0;
    cyc(10);
    checks++; if (strobes() - s0 !== 0) begin errors++; $display("FAIL bounce_no_event got=%0d exp=0", strobes() - s0); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL bounce_state got=%0d exp=0", state_o); end
    a0 = n_ld_a;
    bus.btn_load = 1'b1;
    cyc(40);
    checks++; if (n_ld_a - a0 !== 1) begin errors++; $display("FAIL bounce_hold_one got=%0d exp=1", n_ld_a - a0); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL bounce_hold_state got=%0d exp=1", state_o); end
    release_btn();
    apply_reset();
  endtask
`else
  task automatic test_toggle_events();
    int a0, b0;
    a0 = n_ld_a;
    b0 = n_ld_b;
    bus.btn_load = 1'b1; cyc(3);
    bus.btn_load = 1'b0; cyc(3);
    bus.btn_load = 1'b1; cyc(3);
    bus.btn_load = 1'b0; cyc(4);
    checks++; if (n_ld_a - a0 !== 1) begin errors++; $display("FAIL toggle_ld_a got=%0d exp=1", n_ld_a - a0); end
    checks++; if (n_ld_b - b0 !== 1) begin errors++; $display("FAIL toggle_ld_b got=%0d exp=1", n_ld_b - b0); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL toggle_state got=%0d exp=2", state_o); end
    apply_reset();
  endtask
`endif

  task automatic test_cancel();
    int s0, a0;
    apply_reset();
    press_to_ld(8'h11);
    release_btn();
    press_to_ld(8'h22);
    release_btn();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL cancel_setup_state got=%0d exp=2", state_o); end
    s0 = strobes();
    bus.btn_cancel = 1'b1;
    cyc(1);
    bus.btn_cancel = 1'b0;
    cyc(4);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL cancel_state got=%0d exp=0", state_o); end
    checks++; if (strobes() - s0 !== 0) begin errors++; $display("FAIL cancel_no_strobe got=%0d exp=0", strobes() - s0); end
    checks++; if ({bus.a_out, bus.b_out} !== 16'h1122) begin errors++; $display("FAIL cancel_retain got=%h exp=1122", {bus.a_out, bus.b_out}); end
    // Cancel lands on the same edge as the press and must swallow it.
    a0 = n_ld_a;
    bus.sw = 8'h99;
    cyc(1);
    bus.btn_load = 1'b1;
    cyc(LAT - 2);
    bus.btn_cancel = 1'b1;
    cyc(1);
    bus.btn_cancel = 1'b0;
    cyc(LAT + 6);
    checks++; if (n_ld_a - a0 !== 0) begin errors++; $display("FAIL cancel_press_ld_a got=%0d exp=0", n_ld_a - a0); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL cancel_press_state got=%0d exp=0", state_o); end
    checks++; if (bus.a_out !== 8'h11) begin errors++; $display("FAIL cancel_press_a_out got=%h exp=11", bus.a_out); end
    release_btn();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press_to_ld(8'h77);
    release_btn();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL rstmid_setup_state got=%0d exp=1", state_o); end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++; if ({bus.a_out, bus.b_out} !== 16'h0000) begin errors++; $display("FAIL rstmid_values got=%h exp=0000", {bus.a_out, bus.b_out}); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", state_o); end
    cyc(2);
    // Button already held when reset releases.
    bus.sw = 8'h5A;
    bus.btn_load = 1'b1;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++; if (bus.ld_a !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL held_rst_clear got=%b/%0d exp=0/0", bus.ld_a, state_o); end
    cyc(LAT);
    checks++; if (bus.ld_a !== 1'b0) begin errors++; $display("FAIL held_early_ld_a got=%b exp=0", bus.ld_a); end
    cyc(1);
    checks++; if (bus.ld_a !== 1'b1) begin errors++; $display("FAIL held_ld_a got=%b exp=1", bus.ld_a); end
    checks++; if (bus.a_out !== 8'h5A) begin errors++; $display("FAIL held_a_out got=%h exp=5a", bus.a_out); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL held_state got=%0d exp=1", state_o); end
    release_btn();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_seq();
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    test_bounce();
`else
    test_toggle_events();
`endif
    test_cancel();
    test_reset_mid();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=scenario completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
